// File: rtl/branch_ctrl_pkg.sv
// Shared CPU definitions for branch resolution: FSM states, branch op codes
// and RISC-V branch funct3 encodings.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EVAL     = 2'b01,
    ST_REDIRECT = 2'b10
  } state_e;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_JAL    = 2'b01;
  localparam logic [1:0] OP_JALR   = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_ctrl_comp.sv
// Operand comparator shared by all conditional branches: equality plus
// less-than, signed or unsigned as selected by brun_sel.
module branch_comp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        brun_sel,
  output logic        eq,
  output logic        lt
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a;
  assign b_s = b;
  assign eq  = (a == b);
  assign lt  = brun_sel ? (a < b) : (a_s < b_s);

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution controller: captures a request, evaluates it one
// cycle later, then raises a fetch redirect held until acknowledged.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [1:0]       br_op,
  input  logic [2:0]       br_funct3,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             illegal,
  output logic             misalign,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e      state;
  logic [1:0]  op_p0;
  logic [2:0]  f3_p0;
  logic [31:0] pc_p0, imm_p0, rs1_p0, rs2_p0;
  logic        eq, lt;
  logic        cond, ill, mis, take;
  logic [31:0] target;

  assign br_ready = (state == ST_IDLE);

  // Stage p0: request capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (br_valid && br_ready) begin
      op_p0  <= br_op;
      f3_p0  <= br_funct3;
      pc_p0  <= br_pc;
      imm_p0 <= br_imm;
      rs1_p0 <= rs1_data;
      rs2_p0 <= rs2_data;
    end
  end

  branch_comp u_comp (
    .a        (rs1_p0),
    .b        (rs2_p0),
    .brun_sel (f3_p0[1]),
    .eq       (eq),
    .lt       (lt)
  );

  always_comb begin
    cond = 1'b0;
    ill  = 1'b0;
    case (op_p0)
      OP_BRANCH: begin
        case (f3_p0)
          F3_BEQ:  cond = eq;
          F3_BNE:  cond = !eq;
          F3_BLT:  cond = lt;
          F3_BGE:  cond = !lt;
          F3_BLTU: cond = lt;
          F3_BGEU: cond = !lt;
          default: ill  = 1'b1;
        endcase
      end
      OP_JAL, OP_JALR: cond = 1'b1;
      default:         ill  = 1'b1;
    endcase
    target = (op_p0 == OP_JALR) ? ((rs1_p0 + imm_p0) & ~32'd1) : (pc_p0 + imm_p0);
    mis    = cond && target[1];
    take   = cond && !mis;
  end

  // Stage p1: resolution pulses and redirect state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      illegal        <= 1'b0;
      misalign       <= 1'b0;
    end else begin
      flush         <= 1'b0;
      resolve_valid <= 1'b0;
      resolve_taken <= 1'b0;
      illegal       <= 1'b0;
      misalign      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (br_valid) state <= ST_EVAL;
        end
        ST_EVAL: begin
          resolve_valid <= 1'b1;
          resolve_taken <= take;
          illegal       <= ill;
          misalign      <= mis;
          if (take) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
            flush          <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ack) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p2: statistics, clear has priority over the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (cnt_clr) begin
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if (resolve_valid) br_count    <= sat_inc(br_count);
      if (resolve_taken) taken_count <= sat_inc(taken_count);
    end
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port br_valid  input  1  branch/jump request from decode.
REQ-005 SHALL have port br_ready  output  1  controller can accept a request.
REQ-006 SHALL have port br_op  input  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved.
REQ-007 SHALL have port br_funct3  input  3  RISC-V branch funct3.
REQ-008 SHALL have ports br_pc, br_imm, rs1_data, rs2_data  input  32 each  PC, sign-extended immediate, operands.
REQ-009 SHALL have port redirect_valid  output  1  fetch redirect pending.
REQ-010 SHALL have port redirect_pc  output  32  redirect target.
REQ-011 SHALL have port redirect_ack  input  1  fetch accepted redirect.
REQ-012 SHALL have port flush  output  1  one-cycle pulse to squash younger instructions.
REQ-013 SHALL have ports resolve_valid, resolve_taken  output  1 each  resolution pulse and outcome.
REQ-014 SHALL have ports illegal, misalign  output  1 each  one-cycle exception pulses.
REQ-015 SHALL have port cnt_clr  input  1  synchronous clear of statistics counters.
REQ-016 SHALL have ports br_count, taken_count  output  CNT_W each  resolved and taken totals.

Function
REQ-017 SHALL implement FSM states IDLE, EVAL, REDIRECT; br_ready=1 only in IDLE.
REQ-018 IDLE: on br_valid&&br_ready SHALL register op, funct3, pc, imm, rs1, rs2 and go to EVAL.
REQ-019 EVAL SHALL drive the comparator from registered operands only, brun_sel=funct3[1].
REQ-020 Taken SHALL be: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 lt(unsigned), 111 !lt(unsigned); JAL/JALR always taken.
REQ-021 funct3 010/011 with op 00, or op 11, SHALL pulse illegal, be not-taken, and not redirect.
REQ-022 Target SHALL be pc+imm for op 00/01 and (rs1+imm)&~1 for JALR, modulo 2^32 wrap.
REQ-023 Taken with target[1]=1 SHALL pulse misalign, no redirect, no flush, resolve_taken=0.
REQ-024 At the EVAL exit edge SHALL register resolve_valid=1 for exactly one cycle with resolve_taken.
REQ-025 Valid taken SHALL go to REDIRECT, load redirect_pc, set redirect_valid, pulse flush in the same cycle as resolve_valid.
REQ-026 Not-taken, illegal or misaligned SHALL return to IDLE.
REQ-027 Accept-to-resolve latency SHALL be 2 edges; not-taken throughput SHALL be one request per 2 cycles.
REQ-028 REDIRECT SHALL hold redirect_valid and redirect_pc stable until redirect_ack, then go to IDLE at that edge.
REQ-029 redirect_ack outside REDIRECT SHALL be ignored.
REQ-030 br_count SHALL increment on every resolve_valid, taken_count on resolve_taken; both saturate at all-ones.
REQ-031 cnt_clr SHALL win over a simultaneous increment, both counters reading 0 next cycle.

Reset
REQ-032 rst_n low SHALL immediately force IDLE; outputs redirect_valid, flush, resolve_valid, resolve_taken, illegal, misalign 0; redirect_pc 0; counters 0.
REQ-033 Reset during EVAL or REDIRECT SHALL drop the in-flight request with no pulse after release.
REQ-034 br_ready SHALL read 1 in the first cycle after rst_n deasserts.

Structure
REQ-035 State encoding, br_op codes and funct3 constants SHALL live in the shared CPU package.
REQ-036 The comparison SHALL use one instance of the existing branch_comp sub-module; no duplicate comparator.

Verification
REQ-037 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> resolve_taken=1, flush pulse, redirect_pc=0x120, held until ack.
REQ-038 BLTU same operands -> resolve_taken=0, no redirect, br_ready=1 with the resolve pulse.
REQ-039 JALR rs1=0x1003, imm=0 -> target 0x1002, misalign pulse, no redirect; funct3=010 -> illegal pulse.
REQ-040 Redirect with ack delayed 5 cycles, br_valid held high -> no acceptance until the ack edge, redirect_pc stable.
REQ-041 rst_n low during REDIRECT -> redirect_valid 0 immediately, no resolve pulse after release; 0xFFFF taken branches plus one more -> taken_count=0xFFFF; cnt_clr with resolve -> 0.
